// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop sync, debounce FSM, press/release/long pulses.
// Long-press counter built only with BUTTON_DEBOUNCE_LONG_PRESS_EN defined.
module button_debounce #(
  parameter int ACTIVE_LOW      = 1,
  parameter int DEBOUNCE_CYCLES = 388800,
  parameter int CNT_W           = 20,
  parameter int LONG_CYCLES     = 38880000,
  parameter int LONG_W          = 26
) (
  input  logic clk_tcxo,
  input  logic rst_n,
  input  logic btn_in,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_ARMING,
    S_PRESSED,
    S_DISARMING
  } state_e;

  localparam logic IDLE_LVL = (ACTIVE_LOW != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2 ||
      DEBOUNCE_CYCLES >= (1 << CNT_W) ||
      LONG_CYCLES >= (1 << LONG_W)) begin : g_param_err
    $error("button_debounce: illegal parameters");
  end

  logic [1:0]       sync_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             act;

  assign act = sync_q[1] ^ IDLE_LVL;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      S_RELEASED: begin
        if (act) begin
          state_d = S_ARMING;
          cnt_d   = '0;
        end
      end
      S_ARMING: begin
        if (!act) begin
          state_d = S_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_PRESSED: begin
        if (!act) begin
          state_d = S_DISARMING;
          cnt_d   = '0;
        end
      end
      S_DISARMING: begin
        if (act) begin
          state_d = S_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_RELEASED;
          level_d = 1'b0;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_RELEASED;
    endcase
  end

  always_ff @(posedge clk_tcxo or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= {2{IDLE_LVL}};
      state_q <= S_RELEASED;
      cnt_q   <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_in};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_SAT  = LONG_W'(LONG_CYCLES);

  logic [LONG_W-1:0] lcnt_q, lcnt_d;
  logic              long_q, long_d;

  // Parks at LONG_CYCLES so only one pulse fires per press.
  always_comb begin
    lcnt_d = lcnt_q;
    long_d = 1'b0;
    if (press_d) begin
      lcnt_d = '0;
    end else if (state_q == S_PRESSED) begin
      long_d = (lcnt_q == LONG_LAST);
      if (lcnt_q != LONG_SAT) begin
        lcnt_d = lcnt_q + LONG_W'(1);
      end
    end
  end

  always_ff @(posedge clk_tcxo or negedge rst_n) begin
    if (!rst_n) begin
      lcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      lcnt_q <= lcnt_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: segment table, timed corner cases, random vs model.
// Honours BUTTON_DEBOUNCE_LONG_PRESS_EN for long_press expectations.
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 10;
`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int LP = 1;
`else
  localparam int LP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic btn;
  logic level, press, rel, long_press;

  always #5 clk = ~clk;

  button_debounce #(
    .ACTIVE_LOW(1),
    .DEBOUNCE_CYCLES(D),
    .CNT_W(3),
    .LONG_CYCLES(L),
    .LONG_W(4)
  ) dut (
    .clk_tcxo(clk),
    .rst_n(rst_n),
    .btn_in(btn),
    .level(level),
    .press(press),
    .release_pulse(rel),
    .long_press(long_press)
  );

  int checks = 0;
  int fails  = 0;

  // Reference: act lags the pin by two samples; level flips once act has
  // disagreed with it on D+1 consecutive edges.
  bit m_h0, m_h1, m_level, m_press, m_rel, m_long;
  int m_run, m_lc;
  int n_press, n_rel, n_long;

  typedef struct {
    logic b;
    int   n;
    int   np;
    int   nr;
    logic lvl;
    int   nl;
  } vec_t;

  vec_t tbl[19];

  task automatic check(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b want %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s: got %0d want %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_h0 = 0; m_h1 = 0;
    m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
    m_run = 0; m_lc = 0;
  endtask

  task automatic model_step(input logic b);
    bit a, pst;
    a = m_h1;
    pst = m_level && (m_run == 0);
    m_press = 0; m_rel = 0; m_long = 0;
    m_h1 = m_h0;
    m_h0 = ~b;
    if (pst) begin
      if (m_lc == L - 1) m_long = 1;
      if (m_lc != L) m_lc++;
    end
    if (a != m_level) m_run++;
    else m_run = 0;
    if (m_run == D + 1) begin
      m_level = ~m_level;
      m_run = 0;
      if (m_level) begin
        m_press = 1;
        m_lc = 0;
      end else begin
        m_rel = 1;
      end
    end
  endtask

  task automatic tick(input logic b);
    btn = b;
    @(posedge clk);
    model_step(b);
    #1;
    check("level", level, m_level);
    check("press", press, m_press);
    check("release", rel, m_rel);
    check("long_press", long_press, (LP != 0) ? m_long : 1'b0);
    n_press += int'(press);
    n_rel   += int'(rel);
    n_long  += int'(long_press);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_level"}, level, 1'b0);
    check({tag, "_press"}, press, 1'b0);
    check({tag, "_release"}, rel, 1'b0);
    check({tag, "_long"}, long_press, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{1'b1, 20, 0, 0, 1'b0, 0};
    tbl[1]  = '{1'b0, 12, 1, 0, 1'b1, 0};
    tbl[2]  = '{1'b1,  3, 0, 0, 1'b1, 0};
    tbl[3]  = '{1'b0, 10, 0, 0, 1'b1, LP};
    tbl[4]  = '{1'b1, 12, 0, 1, 1'b0, 0};
    tbl[5]  = '{1'b0,  1, 0, 0, 1'b0, 0};
    tbl[6]  = '{1'b1, 10, 0, 0, 1'b0, 0};
    tbl[7]  = '{1'b0,  2, 0, 0, 1'b0, 0};
    tbl[8]  = '{1'b1, 10, 0, 0, 1'b0, 0};
    tbl[9]  = '{1'b0,  3, 0, 0, 1'b0, 0};
    tbl[10] = '{1'b1, 10, 0, 0, 1'b0, 0};
    tbl[11] = '{1'b0,  4, 0, 0, 1'b0, 0};
    tbl[12] = '{1'b1, 10, 0, 0, 1'b0, 0};
    tbl[13] = '{1'b0,  5, 0, 0, 1'b0, 0};
    tbl[14] = '{1'b1, 12, 1, 1, 1'b0, 0};
    tbl[15] = '{1'b0, 40, 1, 0, 1'b1, LP};
    tbl[16] = '{1'b1, 12, 0, 1, 1'b0, 0};
    tbl[17] = '{1'b0, 12, 1, 0, 1'b1, 0};
    tbl[18] = '{1'b1, 12, 0, 1, 1'b0, 0};

    rst_n = 1'b0;
    btn = 1'b1;
    model_reset();
    n_press = 0; n_rel = 0; n_long = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outs("reset");
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      n_press = 0; n_rel = 0; n_long = 0;
      for (int k = 0; k < tbl[i].n; k++) tick(tbl[i].b);
      check_int($sformatf("seg%0d_press", i), n_press, tbl[i].np);
      check_int($sformatf("seg%0d_release", i), n_rel, tbl[i].nr);
      check($sformatf("seg%0d_level", i), level, tbl[i].lvl);
      check_int($sformatf("seg%0d_long", i), n_long, tbl[i].nl);
    end

    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      check("t_press", press, i == 6);
      check("t_level", level, i >= 6);
    end
    for (int i = 0; i < 10; i++) begin
      tick(1'b1);
      check("t_release", rel, i == 6);
      check("t_level_off", level, i < 6);
    end

    tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_arm");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      check("ra_press", press, i == 6);
    end
    check("ra_level", level, 1'b1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs("rst_prs");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    n_rel = 0;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      check("rp_press", press, i == 6);
    end
    check_int("rp_no_release", n_rel, 0);
    for (int i = 0; i < 12; i++) tick(1'b1);

    for (int s = 0; s < 120; s++) begin
      logic b;
      int len;
      b = logic'($urandom_range(0, 1));
      len = (s % 10 == 0) ? int'($urandom_range(10, 25)) : int'($urandom_range(1, 8));
      for (int k = 0; k < len; k++) tick(b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
